// File: rtl/decoder_nx2n_scan_if.sv
// decoder_nx2n_scan_if: control and decode bus between a sequencer driver and the decoder
interface decoder_nx2n_scan_if #(
    parameter int SEL_W = 3
) ();
    logic en;
    logic mode;
    logic load;
    logic [SEL_W-1:0] sel;
    logic [2**SEL_W-1:0] out;
    logic [SEL_W-1:0] idx;
    logic wrap;
    modport master (output en, mode, load, sel, input out, idx, wrap);
    modport slave (input en, mode, load, sel, output out, idx, wrap);
endinterface

// File: rtl/decoder_nx2n_scan.sv
// decoder_nx2n_scan: registered N-to-2^N one-hot decoder with direct index and timed scan modes
module decoder_nx2n_scan #(
    parameter int SEL_W = 3,
    parameter int DWELL = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input logic clk,
    input logic rst,
    decoder_nx2n_scan_if.slave bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] LAST = DW'(DWELL - 1);
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
    state_t state, state_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [SEL_W-1:0] idx, idx_n;
    logic [OUT_W-1:0] out, out_n;
    logic wrap, wrap_n, step, adv;
    always_comb begin
        state_n = !bus.en ? IDLE : bus.mode ? SCAN : DIRECT;
        step = state == SCAN && state_n == SCAN && !bus.load;
        adv = step && dwell == LAST;
        idx_n = state_n == IDLE ? idx
              : bus.load ? bus.sel
              : (state_n == SCAN && state == IDLE) ? '0
              : adv ? idx + 1'b1
              : idx;
        dwell_n = step && !adv ? dwell + 1'b1 : '0;
        wrap_n = adv && &idx;
        // out is computed from the next index so it lands on the same edge as idx
        out_n = state_n == IDLE ? {OUT_W{ACTIVE_LOW}} : (OUT_W'(1) << idx_n) ^ {OUT_W{ACTIVE_LOW}};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            dwell <= '0;
            wrap <= 1'b0;
            out <= {OUT_W{ACTIVE_LOW}};
        end else begin
            state <= state_n;
            idx <= idx_n;
            dwell <= dwell_n;
            wrap <= wrap_n;
            out <= out_n;
        end
    end
    assign bus.out = out;
    assign bus.idx = idx;
    assign bus.wrap = wrap;
endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// tb_decoder_nx2n_scan: three parameter lanes driven in lockstep, scoreboarded against a behavioural model
module tb_decoder_nx2n_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decoder_nx2n_scan_if #(.SEL_W(3)) b0 ();
    decoder_nx2n_scan_if #(.SEL_W(1)) b1 ();
    decoder_nx2n_scan_if #(.SEL_W(2)) b2 ();

    decoder_nx2n_scan #(.SEL_W(3), .DWELL(4), .ACTIVE_LOW(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    decoder_nx2n_scan #(.SEL_W(1), .DWELL(1), .ACTIVE_LOW(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    decoder_nx2n_scan #(.SEL_W(2), .DWELL(4), .ACTIVE_LOW(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    logic [63:0] a_out [3];
    logic [7:0] a_idx [3];
    logic a_wrap [3];
    assign a_out[0] = 64'(b0.out);
    assign a_out[1] = 64'(b1.out);
    assign a_out[2] = 64'(b2.out);
    assign a_idx[0] = 8'(b0.idx);
    assign a_idx[1] = 8'(b1.idx);
    assign a_idx[2] = 8'(b2.idx);
    assign a_wrap[0] = b0.wrap;
    assign a_wrap[1] = b1.wrap;
    assign a_wrap[2] = b2.wrap;

    typedef struct packed {
        logic [2:0][63:0] out;
        logic [2:0][7:0] idx;
        logic [2:0] wrap;
    } exp_t;
    exp_t q[$];

    int sw [3] = '{3, 1, 2};
    int dwl [3] = '{4, 1, 4};
    bit al [3] = '{1'b0, 1'b0, 1'b1};
    int m_st [3];
    int m_idx [3];
    int m_held [3];
    bit m_wr [3];

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // m_st: 0 idle, 1 direct, 2 scan; m_held counts cycles already spent at the current scan position
    task automatic step(input int k, input bit r, input bit e, input bit md, input bit ld, input int s);
        int n = 1 << sw[k];
        s = s % n;
        m_wr[k] = 1'b0;
        if (r) begin
            m_st[k] = 0; m_idx[k] = 0; m_held[k] = 0;
        end else if (!e) begin
            m_st[k] = 0; m_held[k] = 0;
        end else if (!md) begin
            if (ld) m_idx[k] = s;
            m_st[k] = 1; m_held[k] = 0;
        end else if (ld) begin
            m_idx[k] = s; m_st[k] = 2; m_held[k] = 0;
        end else if (m_st[k] != 2) begin
            if (m_st[k] == 0) m_idx[k] = 0;
            m_st[k] = 2; m_held[k] = 0;
        end else begin
            m_held[k]++;
            if (m_held[k] == dwl[k]) begin
                m_held[k] = 0;
                m_wr[k] = (m_idx[k] == n - 1);
                m_idx[k] = (m_idx[k] + 1) % n;
            end
        end
    endtask

    function automatic logic [63:0] exp_out(input int k);
        logic [63:0] mask = (64'd1 << (1 << sw[k])) - 64'd1;
        logic [63:0] o = m_st[k] == 0 ? 64'd0 : 64'd1 << m_idx[k];
        return al[k] ? ~o & mask : o;
    endfunction

    task automatic push(input bit r, input bit e, input bit md, input bit ld, input int s);
        exp_t x;
        for (int k = 0; k < 3; k++) begin
            step(k, r, e, md, ld, s);
            x.out[k] = exp_out(k);
            x.idx[k] = 8'(m_idx[k]);
            x.wrap[k] = m_wr[k];
        end
        q.push_back(x);
    endtask

    task automatic drive(input bit e, input bit md, input bit ld, input int s);
        b0.en = e; b1.en = e; b2.en = e;
        b0.mode = md; b1.mode = md; b2.mode = md;
        b0.load = ld; b1.load = ld; b2.load = ld;
        b0.sel = 3'(s); b1.sel = 1'(s); b2.sel = 2'(s);
    endtask

    task automatic cyc(input bit r, input bit e, input bit md, input bit ld, input int s);
        @(negedge clk);
        rst = r;
        drive(e, md, ld, s);
        push(r, e, md, ld, s);
    endtask

    task automatic run(input int n, input bit e, input bit md);
        for (int i = 0; i < n; i++) cyc(1'b0, e, md, 1'b0, 0);
    endtask

    task automatic async_rst();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_out0", a_out[0], 64'h0);
        chk("async_idx0", 64'(a_idx[0]), 64'h0);
        chk("async_wrap0", 64'(a_wrap[0]), 64'h0);
        chk("async_out2", a_out[2], 64'hF);
        push(1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow at %0t: got empty queue expected entry", $time);
            end else begin
                e = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("out%0d", k), a_out[k], e.out[k]);
                    chk($sformatf("idx%0d", k), 64'(a_idx[k]), 64'(e.idx[k]));
                    chk($sformatf("wrap%0d", k), 64'(a_wrap[k]), 64'(e.wrap[k]));
                end
            end
        end
    end

    initial begin
        bit md = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, i[0], i[1], i + 3);
        for (int s = 0; s < 8; s++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, s);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 7 - s);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
        end
        run(1, 1'b0, 1'b0);
        run(34, 1'b1, 1'b1);
        run(1, 1'b0, 1'b0);
        run(16, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 6);
        run(6, 1'b1, 1'b1);
        run(1, 1'b0, 1'b0);
        run(9, 1'b1, 1'b1);
        run(10, 1'b1, 1'b0);
        run(6, 1'b1, 1'b1);
        run(2, 1'b0, 1'b0);
        run(21, 1'b1, 1'b1);
        async_rst();
        run(12, 1'b1, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(9) == 0) md = ~md;
            cyc($urandom_range(499) == 0, $urandom_range(9) != 0, md,
                $urandom_range(9) == 0, int'($urandom_range(7)));
        end
        @(posedge clk);
        #2;
        chk("queue_drain", 64'(q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decoder_nx2n_scan.md
# decoder_nx2n_scan

Parametrised, registered N-to-2^N one-hot decoder with a built-in scan sequencer. It is the successor to the team's fixed-width enable-gated 1x2/2x4/3x8 decoders. In DIRECT mode it decodes a loaded index. In SCAN mode it walks the active output through all 2^N positions with a programmable dwell time. It drives row/digit strobes, chip selects and time-multiplexed enables.

## Interface
- SEL_W, default 3: index width; output width OUT_W = 2**SEL_W; legal range 1..6.
- DWELL, default 4: clock cycles each position is held in SCAN mode; legal range ≥1.
- ACTIVE_LOW, default 0: 1 inverts `out` (one-cold); all internal logic unchanged.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; low forces IDLE.
- mode  in  1  0 = DIRECT, 1 = SCAN; sampled only while en=1.
- load  in  1  capture `sel` into the index register this cycle.
- sel  in  SEL_W  index to load.
- out  out  OUT_W  registered one-hot decode of idx. Bit k is active when idx==k, never active in IDLE.
- idx  out  SEL_W  current index register.
- wrap  out  1  one-cycle pulse on the SCAN advance from OUT_W-1 to 0.

## Operation
- States: IDLE, DIRECT, SCAN. The state register, idx, dwell counter, out and wrap are all flops.
- Reset (async, immediate): state=IDLE, idx=0, dwell=0, wrap=0, out=all inactive (0s, or all 1s when ACTIVE_LOW=1).
- Any state with en=0 → IDLE next edge. In IDLE: out inactive, idx held, dwell=0, wrap=0, load ignored.
- IDLE with en=1: → DIRECT if mode=0; → SCAN if mode=1. Entering SCAN from IDLE sets idx=0 and dwell=0, unless load=1, in which case idx=sel.
- DIRECT: idx←sel when load=1, else held. The dwell counter is held at 0. out = onehot(idx).
- DIRECT→SCAN (mode 0→1): idx continues from its current value and dwell restarts at 0.
- SCAN→DIRECT (mode 1→0): idx frozen at its current value and dwell cleared.
- SCAN, load=0: dwell counts 0..DWELL-1. When dwell==DWELL-1, dwell←0 and idx←idx+1 modulo OUT_W. wrap=1 on the edge where idx goes OUT_W-1→0, else 0.
- SCAN, load=1: idx←sel and dwell←0. Load has priority over a coincident advance. No wrap is generated by a load.
- DWELL=1: idx advances every cycle in SCAN. The dwell counter width is max(1, clog2(DWELL)).
- Exactly one out bit is active in DIRECT and SCAN. There are no glitches, because out is a flop and not decoded combinationally.

## Timing
- out, idx and wrap update on the same rising edge. out always equals onehot(idx) in non-IDLE states.
- Load latency: load asserted before edge k gives idx=sel and matching out from edge k. That is 1 cycle.
- en falling before edge k gives out inactive from edge k. en rising before edge k gives out active from edge k.
- SCAN period: each position is held exactly DWELL cycles. A full sweep takes OUT_W*DWELL cycles. wrap fires once per sweep.
- rst asserted mid-scan clears outputs asynchronously, without waiting for a clock. The first post-reset edge with en=1 behaves as IDLE→target state.
- Inputs are synchronous to clk. The block has no combinational path from any input to any output.

## Test plan
- Reset/IDLE: assert rst mid-SCAN with idx=5 → out=0x00, idx=0 and wrap=0 immediately. With en=0 for 10 cycles and load pulses → out stays 0x00.
- DIRECT decode (SEL_W=3): en=1, mode=0, load sel=0..7 in turn → out=0x01,0x02,…,0x80 one cycle after each load. out holds with load=0.
- SCAN sweep (DWELL=4): en=1, mode=1 from IDLE → idx 0,0,0,0,1,1,1,1,…,7. wrap is a single-cycle pulse when idx returns to 0 at cycle 32. out stays one-hot throughout.
- Load priority: in SCAN with idx=3 and dwell=3, assert load sel=6 → next idx=6 (not 4), dwell=0, wrap=0. Position 6 is then held 4 cycles.
- Mode switching: SCAN at idx=2 → mode=0 → idx stays 2 indefinitely. mode=1 again → idx=2 held 4 cycles, then advances to 3. Dropping en → out=0x00 next edge.
- Parameter corners: SEL_W=1, DWELL=1 → out alternates 0b01/0b10 every cycle and wrap fires every 2 cycles. ACTIVE_LOW=1, SEL_W=2 → reset value out=0xF, and DIRECT sel=2 gives out=0xB.
